// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, instruction opcodes and IR capture pattern
package jtag_pkg;
  typedef enum logic [3:0] {
    S_TLR, S_RTI, S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
  } tap_state_e;
  localparam int OP_EXTEST = 0;
  localparam int OP_IDCODE = 1;
  localparam int OP_SAMPLE = 2;
  localparam int OP_CLAMP  = 3;
  localparam int OP_INTEST = 4;
  localparam int OP_USER0  = 8;
  localparam logic [1:0] IR_CAPTURE = 2'b01;
  function automatic int op_bypass(input int ir_width);
    return (1 << ir_width) - 1;
  endfunction
endpackage

// File: rtl/jtag_tap_fsm.sv
// jtag_tap_fsm: IEEE 1149.1 TAP state machine with one-hot state decodes
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic tck,
  input  logic trst,
  input  logic tms,
  output logic test_logic_reset,
  output logic capture_ir,
  output logic shift_ir,
  output logic update_ir,
  output logic capture_dr,
  output logic shift_dr,
  output logic update_dr
);
  tap_state_e r_state, w_next;
  always_ff @(posedge tck or negedge trst)
    if (!trst) r_state <= S_TLR;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_TLR:      w_next = tms ? S_TLR : S_RTI;
      S_RTI:      w_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_DR:   w_next = tms ? S_SEL_IR : S_CAP_DR;
      S_CAP_DR:   w_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR: w_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR: w_next = tms ? S_UPD_DR : S_PAUSE_DR;
      S_PAUSE_DR: w_next = tms ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR: w_next = tms ? S_UPD_DR : S_SHIFT_DR;
      S_UPD_DR:   w_next = tms ? S_SEL_DR : S_RTI;
      S_SEL_IR:   w_next = tms ? S_TLR : S_CAP_IR;
      S_CAP_IR:   w_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR: w_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR: w_next = tms ? S_UPD_IR : S_PAUSE_IR;
      S_PAUSE_IR: w_next = tms ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR: w_next = tms ? S_UPD_IR : S_SHIFT_IR;
      S_UPD_IR:   w_next = tms ? S_SEL_DR : S_RTI;
      default:    w_next = S_TLR;
    endcase
  end
  assign test_logic_reset = r_state == S_TLR;
  assign capture_ir       = r_state == S_CAP_IR;
  assign shift_ir         = r_state == S_SHIFT_IR;
  assign update_ir        = r_state == S_UPD_IR;
  assign capture_dr       = r_state == S_CAP_DR;
  assign shift_dr         = r_state == S_SHIFT_DR;
  assign update_dr        = r_state == S_UPD_DR;
endmodule

// File: rtl/jtag_tap_multi_dr.sv
// jtag_tap_multi_dr: 1149.1 TAP with BYPASS, IDCODE, BSR hooks and NUM_USER
// user data registers exposing parallel capture/update to on-chip debug logic
module jtag_tap_multi_dr
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          NUM_USER   = 2,
  parameter int          USER_WIDTH = 32
) (
  input  logic                           tck,
  input  logic                           trst,
  input  logic                           tms,
  input  logic                           tdi,
  output logic                           tdo,
  output logic                           tdo_en,
  output logic                           bsr_tdi,
  output logic                           bsr_shift,
  output logic                           bsr_capture,
  output logic                           bsr_update,
  output logic                           bsr_mode,
  input  logic                           bsr_tdo,
  input  logic [NUM_USER*USER_WIDTH-1:0] usr_capture,
  output logic [NUM_USER*USER_WIDTH-1:0] usr_update,
  output logic [NUM_USER-1:0]            usr_update_stb
);
  if (IR_WIDTH < 4 || NUM_USER < 1 || NUM_USER > 8 || !IDCODE_VAL[0] ||
      OP_USER0 + NUM_USER - 1 >= op_bypass(IR_WIDTH)) begin : g_bad_cfg
    $error("jtag_tap_multi_dr: invalid parameter set");
  end
  localparam logic [IR_WIDTH-1:0] L_IDCODE = IR_WIDTH'(OP_IDCODE);
  logic w_tlr, w_cap_ir, w_shift_ir, w_upd_ir, w_cap_dr, w_shift_dr, w_upd_dr;
  logic [IR_WIDTH-1:0] r_ir_sr, r_ir;
  logic r_bypass, r_tdo, r_tdo_en;
  logic [31:0] r_id;
  logic [NUM_USER-1:0] w_usr_hit, w_usr_lsb;
  logic w_sel_bsr, w_sel_id, w_sel_usr, w_sel_byp, w_dr_tdo;
  jtag_tap_fsm u_fsm (
    .tck              (tck),
    .trst             (trst),
    .tms              (tms),
    .test_logic_reset (w_tlr),
    .capture_ir       (w_cap_ir),
    .shift_ir         (w_shift_ir),
    .update_ir        (w_upd_ir),
    .capture_dr       (w_cap_dr),
    .shift_dr         (w_shift_dr),
    .update_dr        (w_upd_dr)
  );
  assign w_sel_bsr = r_ir == IR_WIDTH'(OP_EXTEST) || r_ir == IR_WIDTH'(OP_SAMPLE) ||
                     r_ir == IR_WIDTH'(OP_INTEST);
  assign w_sel_id  = r_ir == L_IDCODE;
  assign w_sel_usr = |w_usr_hit;
  // CLAMP, BYPASS and every unassigned opcode fall through to the bypass bit
  assign w_sel_byp = !(w_sel_bsr || w_sel_id || w_sel_usr);
  assign w_dr_tdo  = w_sel_bsr ? bsr_tdo : w_sel_id ? r_id[0] :
                     w_sel_usr ? |(w_usr_hit & w_usr_lsb) : r_bypass;
  assign bsr_mode    = r_ir == IR_WIDTH'(OP_EXTEST) || r_ir == IR_WIDTH'(OP_CLAMP) ||
                       r_ir == IR_WIDTH'(OP_INTEST);
  assign bsr_tdi     = tdi;
  assign bsr_shift   = w_shift_dr && w_sel_bsr;
  assign bsr_capture = w_cap_dr && w_sel_bsr;
  assign bsr_update  = w_upd_dr && w_sel_bsr;
  assign tdo         = r_tdo;
  assign tdo_en      = r_tdo_en;
  always_ff @(posedge tck or negedge trst)
    if (!trst) begin
      r_ir_sr <= '0;
      r_ir    <= L_IDCODE;
    end else begin
      r_ir_sr <= w_cap_ir ? {{(IR_WIDTH-2){1'b0}}, IR_CAPTURE} :
                 w_shift_ir ? {tdi, r_ir_sr[IR_WIDTH-1:1]} : r_ir_sr;
      r_ir    <= w_tlr ? L_IDCODE : w_upd_ir ? r_ir_sr : r_ir;
    end
  always_ff @(posedge tck or negedge trst)
    if (!trst) begin
      r_bypass <= 1'b0;
      r_id     <= '0;
    end else begin
      if (w_sel_byp && (w_cap_dr || w_shift_dr)) r_bypass <= w_shift_dr && tdi;
      if (w_sel_id) r_id <= w_cap_dr ? IDCODE_VAL : w_shift_dr ? {tdi, r_id[31:1]} : r_id;
    end
  for (genvar k = 0; k < NUM_USER; k++) begin : g_usr
    logic [USER_WIDTH-1:0] r_sr, r_upd;
    logic r_stb;
    assign w_usr_hit[k] = r_ir == IR_WIDTH'(OP_USER0 + k);
    assign w_usr_lsb[k] = r_sr[0];
    assign usr_update[k*USER_WIDTH +: USER_WIDTH] = r_upd;
    assign usr_update_stb[k] = r_stb;
    always_ff @(posedge tck or negedge trst)
      if (!trst) begin
        r_sr  <= '0;
        r_upd <= '0;
        r_stb <= 1'b0;
      end else begin
        r_stb <= w_upd_dr && w_usr_hit[k];
        if (w_usr_hit[k])
          r_sr <= w_cap_dr ? usr_capture[k*USER_WIDTH +: USER_WIDTH] :
                  w_shift_dr ? {tdi, r_sr[USER_WIDTH-1:1]} : r_sr;
        if (w_upd_dr && w_usr_hit[k]) r_upd <= r_sr;
      end
  end
  always_ff @(negedge tck or negedge trst)
    if (!trst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_shift_ir ? r_ir_sr[0] : w_shift_dr && w_dr_tdo;
      r_tdo_en <= w_shift_ir || w_shift_dr;
    end
endmodule

// File: tb/tb_jtag_tap_multi_dr.sv
// tb_jtag_tap_multi_dr: table-driven IR/DR scans plus reset and pause sequences
module tb_jtag_tap_multi_dr;
  localparam int IRW = 5;
  localparam int NU  = 2;
  localparam int UW  = 32;
  typedef struct {
    string          name;
    logic [IRW-1:0] ir;
    int             len;
    logic [31:0]    din;
    logic [31:0]    exp;
    logic           mode;
    logic           bsr;
    int             usr;
  } vec_t;
  logic tck = 0, trst = 0, tms = 1, tdi = 0;
  logic tdo, tdo_en, bsr_tdi, bsr_shift, bsr_capture, bsr_update, bsr_mode, bsr_tdo;
  logic [NU*UW-1:0] usr_capture = '0;
  logic [NU*UW-1:0] usr_update;
  logic [NU-1:0] usr_update_stb;
  logic [3:0] r_chain = 4'h0;
  logic [UW-1:0] m_upd [NU];
  logic [31:0] q_exp [$];
  logic en_bad;
  int n_chk = 0, n_pass = 0;
  int c_sh, c_cap, c_upd;

  jtag_tap_multi_dr dut (
    .tck            (tck),
    .trst           (trst),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .tdo_en         (tdo_en),
    .bsr_tdi        (bsr_tdi),
    .bsr_shift      (bsr_shift),
    .bsr_capture    (bsr_capture),
    .bsr_update     (bsr_update),
    .bsr_mode       (bsr_mode),
    .bsr_tdo        (bsr_tdo),
    .usr_capture    (usr_capture),
    .usr_update     (usr_update),
    .usr_update_stb (usr_update_stb)
  );

  always #10 tck = ~tck;
  // 4-bit boundary-scan chain model that captures 4'hA
  always @(posedge tck)
    if (bsr_capture) r_chain <= 4'hA;
    else if (bsr_shift) r_chain <= {bsr_tdi, r_chain[3:1]};
  assign bsr_tdo = r_chain[0];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step(input logic t, input logic d);
    tms = t;
    tdi = d;
    @(posedge tck);
    @(negedge tck);
    #1;
    c_sh  += int'(bsr_shift);
    c_cap += int'(bsr_capture);
    c_upd += int'(bsr_update);
  endtask

  task automatic shift(input int n, input logic [31:0] din, input logic last,
                       output logic [31:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      if (tdo_en !== 1'b1) en_bad = 1'b1;
      step(last && i == n - 1, din[i]);
    end
  endtask

  task automatic ir_scan(input logic [IRW-1:0] op);
    logic [31:0] cap;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    q_exp.push_back(32'h1);
    shift(IRW, 32'(op), 1'b1, cap);
    check("ir_capture", 64'(cap), 64'(q_exp.pop_front()));
    step(1, 0); step(0, 0);
  endtask

  task automatic dr_scan(input int n, input logic [31:0] din, output logic [31:0] dout);
    c_sh = 0; c_cap = 0; c_upd = 0;
    step(1, 0); step(0, 0); step(0, 0);
    shift(n, din, 1'b1, dout);
    step(1, 0);
  endtask

  initial begin
    vec_t v [9];
    logic [31:0] w, lo, hi;
    logic [NU-1:0] exp_stb;
    v[0] = '{"bypass", 5'h1F, 4, 32'hD, 32'hA, 1'b0, 1'b0, -1};
    v[1] = '{"user0", 5'd8, 32, 32'hA5A5_5A5A, 32'hCAFE_0123, 1'b0, 1'b0, 0};
    v[2] = '{"user1", 5'd9, 32, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
    v[3] = '{"extest", 5'd0, 4, 32'h5, 32'hA, 1'b1, 1'b1, -1};
    v[4] = '{"undef6", 5'd6, 4, 32'hD, 32'hA, 1'b0, 1'b0, -1};
    v[5] = '{"clamp", 5'd3, 4, 32'h3, 32'h6, 1'b1, 1'b0, -1};
    v[6] = '{"sample", 5'd2, 4, 32'hF, 32'hA, 1'b0, 1'b1, -1};
    v[7] = '{"intest", 5'd4, 4, 32'h0, 32'hA, 1'b1, 1'b1, -1};
    v[8] = '{"undef10", 5'd10, 4, 32'hD, 32'hA, 1'b0, 1'b0, -1};
    foreach (m_upd[k]) m_upd[k] = '0;
    c_sh = 0; c_cap = 0; c_upd = 0; en_bad = 0;

    repeat (3) @(negedge tck);
    #1;
    check("rst tdo/tdo_en", 64'({tdo, tdo_en}), 64'(0));
    check("rst bsr outputs", 64'({bsr_shift, bsr_capture, bsr_update, bsr_mode}), 64'(0));
    check("rst usr_update", 64'(usr_update), 64'(0));
    check("rst usr_update_stb", 64'(usr_update_stb), 64'(0));
    check("rst in tlr", 64'(dut.w_tlr), 64'(1));
    trst = 1;
    step(0, 0);
    q_exp.push_back(32'h1000_0001);
    dr_scan(32, 32'hFFFF_FFFF, w);
    check("idcode after reset", 64'(w), 64'(q_exp.pop_front()));
    step(0, 0);
    check("idcode no stb", 64'(usr_update_stb), 64'(0));

    foreach (v[i]) begin
      if (v[i].usr >= 0) usr_capture[v[i].usr*UW +: UW] = v[i].exp;
      ir_scan(v[i].ir);
      check({v[i].name, " bsr_mode"}, 64'(bsr_mode), 64'(v[i].mode));
      q_exp.push_back(v[i].exp);
      en_bad = 0;
      dr_scan(v[i].len, v[i].din, w);
      check({v[i].name, " tdo"}, 64'(w), 64'(q_exp.pop_front()));
      check({v[i].name, " tdo_en in shift"}, 64'(en_bad), 64'(0));
      check({v[i].name, " bsr counts"}, 64'(c_sh * 100 + c_cap * 10 + c_upd),
            v[i].bsr ? 64'(v[i].len * 100 + 11) : 64'(0));
      check({v[i].name, " mode held"}, 64'(bsr_mode), 64'(v[i].mode));
      check({v[i].name, " stb in update"}, 64'(usr_update_stb), 64'(0));
      step(0, 0);
      exp_stb = v[i].usr >= 0 ? NU'(1 << v[i].usr) : '0;
      if (v[i].usr >= 0) m_upd[v[i].usr] = v[i].din;
      check({v[i].name, " stb"}, 64'(usr_update_stb), 64'(exp_stb));
      check({v[i].name, " usr_update"}, 64'(usr_update), 64'({m_upd[1], m_upd[0]}));
      step(0, 0);
      check({v[i].name, " stb clear"}, 64'(usr_update_stb), 64'(0));
      check({v[i].name, " idle tdo_en"}, 64'(tdo_en), 64'(0));
    end

    // Pause-DR in mid-scan must hold the user shift register
    usr_capture[0 +: UW] = 32'h89AB_CDEF;
    ir_scan(5'd8);
    step(1, 0); step(0, 0); step(0, 0);
    shift(16, 32'h7654_3210, 1'b1, lo);
    step(0, 0); step(0, 0); step(0, 0);
    check("pause tdo_en", 64'(tdo_en), 64'(0));
    step(1, 0); step(0, 0);
    shift(16, 32'h0000_FEDC, 1'b1, hi);
    step(1, 0); step(0, 0);
    m_upd[0] = 32'hFEDC_3210;
    check("pause tdo", 64'({hi[15:0], lo[15:0]}), 64'(32'h89AB_CDEF));
    check("pause usr_update", 64'(usr_update), 64'({m_upd[1], m_upd[0]}));

    // Asynchronous reset in the middle of a USER_0 Shift-DR
    step(1, 0); step(0, 0); step(0, 0);
    shift(10, 32'h3FF, 1'b0, w);
    trst = 0;
    #2;
    foreach (m_upd[k]) m_upd[k] = '0;
    check("midrst tlr", 64'(dut.w_tlr), 64'(1));
    check("midrst usr_update", 64'(usr_update), 64'(0));
    check("midrst stb", 64'(usr_update_stb), 64'(0));
    check("midrst tdo/tdo_en", 64'({tdo, tdo_en}), 64'(0));
    @(negedge tck);
    #1;
    trst = 1;
    step(0, 0);
    q_exp.push_back(32'h1000_0001);
    dr_scan(32, 32'h0, w);
    check("midrst idcode", 64'(w), 64'(q_exp.pop_front()));
    step(0, 0);
    check("midrst no stb", 64'(usr_update_stb), 64'(0));

    // Five tms=1 clocks reach Test-Logic-Reset but keep usr_update
    ir_scan(5'd8);
    dr_scan(32, 32'h0BAD_F00D, w);
    step(0, 0);
    m_upd[0] = 32'h0BAD_F00D;
    ir_scan(5'd0);
    check("tms-rst pre mode", 64'(bsr_mode), 64'(1));
    repeat (5) step(1, 0);
    check("tms-rst tlr", 64'(dut.w_tlr), 64'(1));
    check("tms-rst mode", 64'(bsr_mode), 64'(0));
    check("tms-rst usr_update kept", 64'(usr_update), 64'({m_upd[1], m_upd[0]}));
    step(0, 0);
    q_exp.push_back(32'h1000_0001);
    dr_scan(32, 32'h0, w);
    check("tms-rst idcode", 64'(w), 64'(q_exp.pop_front()));
    step(0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
